// File: rtl/measure_arbiter_if.sv
// Requester and measure-engine signals shared between the arbiter and its neighbours.
// master is the arbiter side; slave is the requester/engine side.
interface measure_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int DATA_W = 22
);
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   ack;
    logic [DATA_W-1:0] ack_data;
    logic              ack_err;
    logic [CH_W-1:0]   chan_sel;
    logic              meas_start;
    logic              meas_done;
    logic [DATA_W-1:0] meas_data;
    logic              busy;
    logic [7:0]        err_cnt;

    modport master (
        input  req, meas_done, meas_data,
        output ack, ack_data, ack_err, chan_sel, meas_start, busy, err_cnt
    );

    modport slave (
        output req, meas_done, meas_data,
        input  ack, ack_data, ack_err, chan_sel, meas_start, busy, err_cnt
    );
endinterface

// File: rtl/measure_arbiter.sv
// Round-robin sharing of one RMS measure engine: grant, settle the mux,
// start the engine, wait for done (or timeout), then ack the granted channel.
module measure_arbiter #(
    parameter int          N_CH        = 4,
    parameter int          CH_W        = 2,
    parameter int          DATA_W      = 22,
    parameter logic [23:0] SETTLE_CYC  = 24'd1000,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
    input  logic clk_sys,
    input  logic rst,
    measure_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, DONE} state_t;

    localparam logic [23:0] SETTLE_LAST  = SETTLE_CYC - 24'd1;
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYC - 24'd1;

    state_t          state;
    logic [23:0]     cnt;
    logic [CH_W-1:0] last;
    logic [CH_W-1:0] grant;

    // Lowest offset from last+1 wins, so scan offsets high to low and keep the final hit.
    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                                input logic [CH_W-1:0] l);
        logic [CH_W-1:0] g;
        int              idx;
        g = l;
        for (int i = N_CH; i >= 1; i--) begin
            idx = int'(l) + i;
            if (idx >= N_CH) idx -= N_CH;
            if (r[CH_W'(idx)]) g = CH_W'(idx);
        end
        return g;
    endfunction

    assign grant = rr_pick(bus.req, last);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= CH_W'(N_CH - 1);
            bus.ack        <= '0;
            bus.ack_data   <= '0;
            bus.ack_err    <= 1'b0;
            bus.chan_sel   <= '0;
            bus.meas_start <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            bus.ack        <= '0;
            bus.meas_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        bus.chan_sel <= grant;
                        last         <= grant;
                        bus.busy     <= 1'b1;
                        cnt          <= '0;
                        if (SETTLE_CYC == '0) begin
                            state          <= START;
                            bus.meas_start <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state          <= START;
                        bus.meas_start <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle takes priority over the timeout.
                    if (bus.meas_done) begin
                        bus.ack_data          <= bus.meas_data;
                        bus.ack_err           <= 1'b0;
                        bus.ack[bus.chan_sel] <= 1'b1;
                        state                 <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        bus.ack_data          <= '0;
                        bus.ack_err           <= 1'b1;
                        bus.ack[bus.chan_sel] <= 1'b1;
                        if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
                        state                 <= DONE;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
